noc_tx_arbiter: RTL and testbench
=================================

NOC_TX_ARBITER -- requirements
Module: noc_tx_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of IP requesters (2..16).
REQ-002 SHALL have parameter BURST, default 2, maximum packets accepted per grant (1..15).
REQ-003 fclk  input  1  fabric clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  PORTS  per-port TX request, held high with stable data until that port's tx_complete is seen.
REQ-006 pkt_in  input  PORTS x packet  per-port packet to send.
REQ-007 snd_q_full  input  1  send queue full.
REQ-008 snd_q_we  output  1  registered single-cycle send queue write strobe.
REQ-009 snd_q_dat  output  packet  registered data accompanying snd_q_we.
REQ-010 tx_complete  output  PORTS  registered one-hot pulse, packet of that port accepted.
REQ-011 grant  output  PORTS  registered one-hot current owner, all zero when idle.
REQ-012 stall_cnt  output  16  saturating count of cycles spent in STALL.

Function
REQ-013 SHALL implement states IDLE, GRANT, ACK, STALL.
REQ-014 IDLE: if any req bit high, select first requester at or after rr_ptr (wrapping modulo PORTS), latch owner index, clear burst count, go GRANT; else stay IDLE.
REQ-015 GRANT, req[owner] high, snd_q_full low: register snd_q_dat = pkt_in[owner], pulse snd_q_we and tx_complete[owner] for exactly one cycle, increment burst count, go ACK.
REQ-016 GRANT, req[owner] high, snd_q_full high: no write, go STALL.
REQ-017 GRANT, req[owner] low: release (rr_ptr = owner+1 mod PORTS), go IDLE, no write.
REQ-018 ACK: one-cycle gap so requester can advance data; if burst count == BURST, release and go IDLE; else go GRANT.
REQ-019 STALL: increment stall_cnt (saturate at 65535); on snd_q_full low go GRANT; if req[owner] drops, release and go IDLE.
REQ-020 Latency req rise (idle arbiter, queue not full) to snd_q_we = 2 cycles; peak throughput 1 packet per 2 cycles.
REQ-021 grant SHALL be one-hot of owner in GRANT, ACK, STALL; zero in IDLE.
REQ-022 Requests changing in non-owner ports SHALL not affect the current grant.
REQ-023 rr_ptr SHALL advance only on release, guaranteeing each continuously requesting port service within PORTS grants.
REQ-024 snd_q_we SHALL never assert while snd_q_full was high at the sampling edge.

Reset
REQ-025 On rst: state IDLE, rr_ptr 0, owner 0, burst count 0, stall_cnt 0, snd_q_we 0, snd_q_dat 0, tx_complete 0, grant 0, immediately without clock.
REQ-026 rst mid-transfer SHALL drop the in-flight grant without tx_complete; requester retries after release.

Structure
REQ-027 packet typedef and port-count limits SHALL come from the shared structs package; state enum local to the module.
REQ-028 Round-robin next-requester search SHALL be a sub-module rr_select (inputs req, rr_ptr; outputs valid, index).

Verification
REQ-029 rst, then req=4'b0001 held, pkt_in[0]=A/B -> snd_q_we at cycles 2 and 4, tx_complete[0] each, grant released after 2 packets (BURST=2).
REQ-030 req=4'b1111 continuous, full low -> grant order port 0,1,2,3,0, each granted 2 packets.
REQ-031 owner port 2 in GRANT, snd_q_full high 5 cycles -> no snd_q_we, stall_cnt=5, write occurs 1 cycle after full drops.
REQ-032 owner port 1 drops req in GRANT -> grant 0 next cycle, rr_ptr=2, no tx_complete.
REQ-033 rst asserted during ACK -> all outputs 0 same cycle, IDLE after deassert, next grant port 0.
REQ-034 req=4'b1000 with rr_ptr=0 -> port 3 granted (wrap search), then rr_ptr=0 after release.

Source files
------------

// File: rtl/noc_tx_arbiter_pkg.sv
// Shared packet type and sizing limits for the NoC TX arbiter.
// Imported by the arbiter top and its round-robin selector.
package noc_tx_arbiter_pkg;

  localparam int PKT_W = 32;

  typedef logic [PKT_W-1:0] packet_t;

  localparam int PORTS_MIN = 2;
  localparam int PORTS_MAX = 16;
  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 15;

  localparam int BCNT_W  = 4;
  localparam int STALL_W = 16;

endpackage

// File: rtl/noc_tx_arbiter_rr_select.sv
// Round-robin search: first requester at or after rr_ptr,
// wrapping modulo PORTS.
module noc_tx_arbiter_rr_select
  import noc_tx_arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  localparam int IDX_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan offsets high to low so the smallest offset wins.
  always_comb begin
    logic [IDX_W:0] sum;
    sum     = '0;
    valid_o = 1'b0;
    index_o = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(PORTS)) begin
        sum = sum - (IDX_W+1)'(PORTS);
      end
      if (req_i[sum[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        index_o = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Round-robin burst arbiter feeding IP packets into one
// NoC send queue, with back-pressure stall accounting.
module noc_tx_arbiter
  import noc_tx_arbiter_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int BURST = 2
) (
  input  logic                        fclk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req,
  input  logic [PORTS-1:0][PKT_W-1:0] pkt_in,
  input  logic                        snd_q_full,
  output logic                        snd_q_we,
  output logic [PKT_W-1:0]            snd_q_dat,
  output logic [PORTS-1:0]            tx_complete,
  output logic [PORTS-1:0]            grant,
  output logic [15:0]                 stall_cnt
);

  localparam int IDX_W = $clog2(PORTS);

  if (PORTS < PORTS_MIN || PORTS > PORTS_MAX) begin : g_bad_ports
    $error("noc_tx_arbiter: PORTS out of range");
  end
  if (BURST < BURST_MIN || BURST > BURST_MAX) begin : g_bad_burst
    $error("noc_tx_arbiter: BURST out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ACK,
    S_STALL
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               we_q, we_d;
  packet_t            dat_q, dat_d;
  logic [PORTS-1:0]   txc_q, txc_d;
  logic [PORTS-1:0]   grant_q, grant_d;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               release_w;
  logic [IDX_W-1:0]   next_ptr;

  noc_tx_arbiter_rr_select #(
    .PORTS (PORTS)
  ) rr_select (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (sel_valid),
    .index_o  (sel_idx)
  );

  assign next_ptr = (owner_q == IDX_W'(PORTS - 1))
                  ? '0
                  : owner_q + IDX_W'(1);

  // Next-state, burst/stall counters and registered outputs.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    bcnt_d    = bcnt_q;
    stall_d   = stall_q;
    we_d      = 1'b0;
    dat_d     = dat_q;
    txc_d     = '0;
    grant_d   = '0;
    release_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_idx;
          bcnt_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!req[owner_q]) begin
          release_w = 1'b1;
        end else if (snd_q_full) begin
          state_d = S_STALL;
        end else begin
          we_d           = 1'b1;
          dat_d          = pkt_in[owner_q];
          txc_d[owner_q] = 1'b1;
          bcnt_d         = bcnt_q + BCNT_W'(1);
          state_d        = S_ACK;
        end
      end
      S_ACK: begin
        if (bcnt_q == BCNT_W'(BURST)) begin
          release_w = 1'b1;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_STALL: begin
        if (stall_q != '1) begin
          stall_d = stall_q + STALL_W'(1);
        end
        if (!req[owner_q]) begin
          release_w = 1'b1;
        end else if (!snd_q_full) begin
          state_d = S_GRANT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (release_w) begin
      state_d  = S_IDLE;
      rr_ptr_d = next_ptr;
    end
    if (state_d != S_IDLE) begin
      grant_d[owner_d] = 1'b1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      bcnt_q   <= '0;
      stall_q  <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      txc_q    <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      bcnt_q   <= bcnt_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      txc_q    <= txc_d;
      grant_q  <= grant_d;
    end
  end

  assign snd_q_we    = we_q;
  assign snd_q_dat   = dat_q;
  assign tx_complete = txc_q;
  assign grant       = grant_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed bench for noc_tx_arbiter (PORTS=4, BURST=2).
// Expected values are hand-computed per step.
module tb_noc_tx_arbiter;
  import noc_tx_arbiter_pkg::*;

  logic                  fclk = 1'b0;
  logic                  rst;
  logic [3:0]            req;
  logic [3:0][PKT_W-1:0] pkt_in;
  logic                  snd_q_full;
  logic                  snd_q_we;
  logic [PKT_W-1:0]      snd_q_dat;
  logic [3:0]            tx_complete;
  logic [3:0]            grant;
  logic [15:0]           stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 fclk = ~fclk;

  noc_tx_arbiter #(
    .PORTS (4),
    .BURST (2)
  ) dut (
    .fclk        (fclk),
    .rst         (rst),
    .req         (req),
    .pkt_in      (pkt_in),
    .snd_q_full  (snd_q_full),
    .snd_q_we    (snd_q_we),
    .snd_q_dat   (snd_q_dat),
    .tx_complete (tx_complete),
    .grant       (grant),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  initial begin
    int p;
    rst        = 1'b0;
    req        = '0;
    snd_q_full = 1'b0;
    for (int i = 0; i < 4; i++) pkt_in[i] = 32'h1000_0000 + 32'(i);
    #1 rst = 1'b1;
    #2;
    chk("rst_we", 32'(snd_q_we), 32'h0);
    chk("rst_dat", snd_q_dat, 32'h0);
    chk("rst_txc", 32'(tx_complete), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    step();
    rst = 1'b0;

    // single requester, two-packet burst
    req       = 4'b0001;
    pkt_in[0] = 32'hA0A0_0001;
    step();
    chk("b1_grant", 32'(grant), 32'h1);
    chk("b1_we_c1", 32'(snd_q_we), 32'h0);
    step();
    chk("b1_we_c2", 32'(snd_q_we), 32'h1);
    chk("b1_dat_a", snd_q_dat, 32'hA0A0_0001);
    chk("b1_txc_a", 32'(tx_complete), 32'h1);
    pkt_in[0] = 32'hB0B0_0002;
    step();
    chk("b1_we_c3", 32'(snd_q_we), 32'h0);
    chk("b1_txc_c3", 32'(tx_complete), 32'h0);
    step();
    chk("b1_we_c4", 32'(snd_q_we), 32'h1);
    chk("b1_dat_b", snd_q_dat, 32'hB0B0_0002);
    step();
    chk("b1_release", 32'(grant), 32'h0);
    req = 4'b0000;
    step();
    chk("b1_idle", 32'(grant), 32'h0);

    // fresh pointer, all ports requesting
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) pkt_in[i] = 32'hC000_0000 + 32'(i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      p = k % 4;
      step();
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(1 << p));
      step();
      chk($sformatf("rr%0d_we1", k), 32'(snd_q_we), 32'h1);
      chk($sformatf("rr%0d_txc1", k), 32'(tx_complete), 32'(1 << p));
      chk($sformatf("rr%0d_dat1", k), snd_q_dat, 32'hC000_0000 + 32'(p));
      step();
      step();
      chk($sformatf("rr%0d_we2", k), 32'(snd_q_we), 32'h1);
      chk($sformatf("rr%0d_txc2", k), 32'(tx_complete), 32'(1 << p));
      step();
      chk($sformatf("rr%0d_rel", k), 32'(grant), 32'h0);
    end
    req = 4'b0000;
    step();

    // port 2 stalled by a full queue for five cycles
    req = 4'b0100;
    step();
    chk("st_grant", 32'(grant), 32'h4);
    snd_q_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("st_nowe%0d", k), 32'(snd_q_we), 32'h0);
    end
    chk("st_cnt4", 32'(stall_cnt), 32'd4);
    chk("st_grant_held", 32'(grant), 32'h4);
    snd_q_full = 1'b0;
    step();
    chk("st_cnt5", 32'(stall_cnt), 32'd5);
    chk("st_we_late", 32'(snd_q_we), 32'h0);
    step();
    chk("st_we", 32'(snd_q_we), 32'h1);
    chk("st_dat", snd_q_dat, 32'hC000_0002);
    chk("st_txc", 32'(tx_complete), 32'h4);
    req = 4'b0000;
    step();
    step();
    chk("st_rel", 32'(grant), 32'h0);
    chk("st_rel_we", 32'(snd_q_we), 32'h0);
    chk("st_cnt_hold", 32'(stall_cnt), 32'd5);

    // port 1 withdraws while granted; pointer must move to 2
    req = 4'b0010;
    step();
    chk("dr_grant", 32'(grant), 32'h2);
    req = 4'b0000;
    step();
    chk("dr_grant0", 32'(grant), 32'h0);
    chk("dr_txc0", 32'(tx_complete), 32'h0);
    chk("dr_we0", 32'(snd_q_we), 32'h0);
    req = 4'b1111;
    step();
    chk("dr_next2", 32'(grant), 32'h4);
    step();
    chk("dr_we2", 32'(snd_q_we), 32'h1);

    // reset during ACK
    rst = 1'b1;
    #1;
    chk("ra_we", 32'(snd_q_we), 32'h0);
    chk("ra_txc", 32'(tx_complete), 32'h0);
    chk("ra_grant", 32'(grant), 32'h0);
    chk("ra_dat", snd_q_dat, 32'h0);
    chk("ra_stall", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("ra_next0", 32'(grant), 32'h1);
    chk("ra_no_txc", 32'(tx_complete), 32'h0);
    req = 4'b0000;
    step();
    step();

    // wrap search from pointer 0 to port 3
    rst = 1'b1;
    #1 rst = 1'b0;
    req = 4'b1000;
    step();
    chk("wr_grant3", 32'(grant), 32'h8);
    step();
    chk("wr_txc3", 32'(tx_complete), 32'h8);
    chk("wr_dat3", snd_q_dat, 32'hC000_0003);
    step();
    step();
    step();
    chk("wr_rel", 32'(grant), 32'h0);
    req = 4'b1111;
    step();
    chk("wr_ptr0", 32'(grant), 32'h1);
    req = 4'b0000;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
